cell_fetch_scheduler: RTL and testbench
=======================================

Name: cell_fetch_scheduler

Overview:
Sequences reads from the 1200-entry cell cache once a frame has been fully written, and streams cells in HOG block order. Each block is a 2x2 cell window, giving 29x39 overlapping blocks. Sits between the cell cache read port and the block-normalization stage. Absorbs the cache's 1-cycle read latency with a credit-managed output FIFO, so downstream backpressure never drops a cell.

Parameters:
CELL_WIDTH, 768, bits per cell histogram word
CELL_NUM, 1200, cells per frame
FRAME_ROW_CNUM, 30, cell rows per frame
FRAME_COL_CNUM, 40, cell columns per frame
CELL_ADDR_W, $clog2(CELL_NUM), cache address width (derived, do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
fetch_start_i  in  1  frame-complete pulse from the write-side controller
cell_rd_en_o  out  1  cell cache read enable
cell_rd_addr_o  out  CELL_ADDR_W  cell cache read address
cell_rd_data_i  in  CELL_WIDTH  cache data, valid the cycle after cell_rd_en_o
cell_valid_o  out  1  output beat valid
cell_ready_i  in  1  downstream ready
cell_data_o  out  CELL_WIDTH  cell histogram
cell_pos_o  out  2  position in block: 0=TL, 1=TR, 2=BL, 3=BR
blk_last_o  out  1  beat is BR cell of a block
frame_last_o  out  1  beat is the last beat of the frame
busy_o  out  1  high from start accept until the last beat handshake
done_o  out  1  one-cycle pulse on the final-beat handshake

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0. Reset mid-frame aborts the frame and discards any in-flight read data.
- Handshake: a beat transfers when cell_valid_o & cell_ready_i. cell_data_o, cell_pos_o, blk_last_o and frame_last_o are held stable while valid & ~ready.
- FSM:
  - IDLE: fetch_start_i moves to FETCH and clears blk_base, blk_col and sub. fetch_start_i is ignored in every other state.
  - FETCH: issues reads. After the read for sub=3 of block (28,38), i.e. address 1199, moves to DRAIN.
  - DRAIN: no reads. On the frame_last handshake, pulses done_o and moves to IDLE.
- Address generation, no multiplier:
  - blk_base = r*40 + c; sub counter 0..3 adds offsets 0, 1, FRAME_COL_CNUM, FRAME_COL_CNUM+1.
  - After sub=3: if blk_col == FRAME_COL_CNUM-2, blk_base += 2 and blk_col = 0; otherwise blk_base += 1 and blk_col += 1.
- Credits:
  - reserved = FIFO occupancy + pending reads; the FIFO is 3 entries deep.
  - Issue a read in FETCH when reserved - pop < 3, where pop = handshake this cycle.
  - Full throughput (1 beat/cycle) is required with cell_ready_i held high.
- Sideband: cell_pos_o, blk_last_o and frame_last_o are computed at issue time and carried in a 1-stage pipe alongside the read. They are written into the FIFO with the data the cycle after issue.
- Latency: start seen in cycle T gives first cell_rd_en_o at T+1 and first cell_valid_o at T+3.
- Beat count per frame: 29*39*4 = 4524.
- Simultaneous push and pop at full or empty FIFO: both occur and occupancy is unchanged. Credit logic guarantees no overflow.

Optional Feature:
CELL_FETCH_PERF_EN
- Defined: adds port stall_cnt_o (out, 16 bits), counting cycles with cell_valid_o & ~cell_ready_i. It saturates at 0xFFFF, clears on start accept and on rst, and holds after done.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: frame geometry constants (rows, columns, cell count), block counts (FRAME_ROW_CNUM-1, FRAME_COL_CNUM-1), cell_pos encodings TL/TR/BL/BR, FSM state encodings.
- Sub-module cell_fetch_fifo: 3-deep synchronous FIFO, width CELL_WIDTH+4, with push, pop, count, full and empty. The scheduler holds only the FSM, address generation and credit logic.

Test Plan:
- Full frame, ready=1, pulse start: addresses 0,1,40,41, 1,2,41,42, …; block (0,38) gives 38,39,78,79 then 40,41,80,81; final block 1158,1159,1198,1199. Expect 4524 beats, done_o at T+4526, blk_last every 4th beat.
- Random ready (50%): data matches the cache model in order, no beat lost or duplicated, outputs stable while stalled, FIFO never exceeds 3.
- ready=0 for 20 cycles after start: cell_rd_en_o issues exactly 3 reads then stops; releasing ready resumes one read per cycle.
- fetch_start_i pulsed at beat 100 and again in DRAIN: ignored, address sequence unchanged, one done_o.
- rst at beat 2000 with a read pending: next cycle all outputs 0; a new start restarts at address 0 with no stale data emitted.
- CELL_FETCH_PERF_EN with ready low for 37 stalled cycles: stall_cnt_o = 37 at done.

Source files
------------

// File: rtl/cell_fetch_scheduler_pkg.sv
// rtl/cell_fetch_scheduler_pkg.sv - shared geometry, encodings and FSM states for the cell fetch scheduler
// Purpose: frame geometry (cell rows/columns/count), HOG block counts, in-block
// cell position codes and scheduler FSM state encodings.
// Ports: none (package).
package cell_fetch_scheduler_pkg;

  localparam int CELL_WIDTH_C     = 768;
  localparam int CELL_NUM_C       = 1200;
  localparam int FRAME_ROW_CNUM_C = 30;
  localparam int FRAME_COL_CNUM_C = 40;

  // 2x2 windows overlap by one cell in each direction
  localparam int BLK_ROW_NUM = FRAME_ROW_CNUM_C - 1;
  localparam int BLK_COL_NUM = FRAME_COL_CNUM_C - 1;

  localparam int FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    POS_TL = 2'd0,
    POS_TR = 2'd1,
    POS_BL = 2'd2,
    POS_BR = 2'd3
  } cell_pos_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/cell_fetch_scheduler_if.sv
// rtl/cell_fetch_scheduler_if.sv - cell cache read port and block-order output stream bundle
// Purpose: groups the cache read handshake and the output beat stream.
// master (scheduler): drives cell_rd_en_o/cell_rd_addr_o and the output beat
//   (cell_valid_o, cell_data_o, cell_pos_o, blk_last_o, frame_last_o);
//   receives cell_rd_data_i and cell_ready_i.
// slave (cache + downstream): the reverse directions.
interface cell_fetch_scheduler_if #(
  parameter int CELL_WIDTH  = 768,
  parameter int CELL_ADDR_W = 11
);
  logic                   cell_rd_en_o;
  logic [CELL_ADDR_W-1:0] cell_rd_addr_o;
  logic [CELL_WIDTH-1:0]  cell_rd_data_i;
  logic                   cell_valid_o;
  logic                   cell_ready_i;
  logic [CELL_WIDTH-1:0]  cell_data_o;
  logic [1:0]             cell_pos_o;
  logic                   blk_last_o;
  logic                   frame_last_o;

  modport master (
    output cell_rd_en_o, cell_rd_addr_o,
    input  cell_rd_data_i,
    output cell_valid_o,
    input  cell_ready_i,
    output cell_data_o, cell_pos_o, blk_last_o, frame_last_o
  );

  modport slave (
    input  cell_rd_en_o, cell_rd_addr_o,
    output cell_rd_data_i,
    input  cell_valid_o,
    output cell_ready_i,
    input  cell_data_o, cell_pos_o, blk_last_o, frame_last_o
  );
endinterface

// File: rtl/cell_fetch_scheduler_fifo.sv
// rtl/cell_fetch_scheduler_fifo.sv - 3-deep synchronous FIFO holding cell data plus sideband
// Purpose: output buffer absorbing the cache read latency.
// Ports: clk, rst (sync active-high); push/push_data write side;
//   pop/pop_data read side (pop_data is the head entry, valid when !empty);
//   count occupancy 0..3; full; empty.
module cell_fetch_fifo
  import cell_fetch_scheduler_pkg::*;
#(
  parameter int WIDTH = 772
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [0:FIFO_DEPTH-1];
  logic [1:0]       wr_ptr_q, rd_ptr_q, count_q;
  logic             do_push, do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop  = pop & ~empty;
  // a push into a full FIFO is accepted when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == 2'(FIFO_DEPTH));
  assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/cell_fetch_scheduler.sv
// rtl/cell_fetch_scheduler.sv - streams cached cells in HOG 2x2 block order with credit-managed output FIFO
// Purpose: after fetch_start_i, reads all 29x39 overlapping 2x2 blocks from the
// cell cache (TL,TR,BL,BR per block) and streams them downstream.
// Ports: clk, rst (sync active-high); fetch_start_i frame-complete pulse;
//   bus (master): cache read port and output beat stream; busy_o frame in
//   progress; done_o pulse on final-beat handshake.
// Optional: CELL_FETCH_PERF_EN adds stall_cnt_o, saturating count of
//   valid & ~ready cycles, cleared on start accept.
module cell_fetch_scheduler
  import cell_fetch_scheduler_pkg::*;
#(
  parameter int CELL_WIDTH     = CELL_WIDTH_C,
  parameter int CELL_NUM       = CELL_NUM_C,
  parameter int FRAME_ROW_CNUM = FRAME_ROW_CNUM_C,
  parameter int FRAME_COL_CNUM = FRAME_COL_CNUM_C
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_start_i,
  cell_fetch_scheduler_if.master bus,
  output logic                   busy_o,
  output logic                   done_o
`ifdef CELL_FETCH_PERF_EN
  ,
  output logic [15:0]            stall_cnt_o
`endif
);

  localparam int CELL_ADDR_W = $clog2(CELL_NUM);
  localparam int COL_W       = $clog2(FRAME_COL_CNUM);

  // base address of the final block (row FRAME_ROW_CNUM-2, col FRAME_COL_CNUM-2)
  localparam logic [CELL_ADDR_W-1:0] LAST_BASE =
    CELL_ADDR_W'((FRAME_ROW_CNUM - 2) * FRAME_COL_CNUM + (FRAME_COL_CNUM - 2));
  localparam logic [CELL_ADDR_W-1:0] ROW_OFS  = CELL_ADDR_W'(FRAME_COL_CNUM);
  localparam logic [COL_W-1:0]       LAST_COL = COL_W'(FRAME_COL_CNUM - 2);

  fetch_state_e state_q, state_d;

  logic [CELL_ADDR_W-1:0] blk_base_q, ofs;
  logic [COL_W-1:0]       blk_col_q;
  logic [1:0]             sub_q;
  logic                   rd_pend_q;
  logic [3:0]             side_q;      // {frame_last, blk_last, pos}

  logic                   issue, start_acc, pop, credit_ok, last_blk;
  logic [2:0]             reserved;
  logic [1:0]             fifo_count;
  logic                   fifo_full, fifo_empty;
  logic [CELL_WIDTH+3:0]  fifo_dout;

  assign pop      = bus.cell_valid_o & bus.cell_ready_i;
  assign last_blk = (sub_q == POS_BR) && (blk_base_q == LAST_BASE);

  // Entries already owned by the FIFO or still in the cache pipe; a slot
  // freed by this cycle's pop may be reused immediately.
  assign reserved  = {1'b0, fifo_count} + {2'b0, rd_pend_q};
  assign credit_ok = fifo_full ? pop : (reserved < 3'd3 + {2'b0, pop});

  always_comb begin
    ofs = '0;
    case (sub_q)
      POS_TL:  ofs = '0;
      POS_TR:  ofs = CELL_ADDR_W'(1);
      POS_BL:  ofs = ROW_OFS;
      default: ofs = ROW_OFS + CELL_ADDR_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    start_acc = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_start_i) begin
          start_acc = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        issue = credit_ok;
        if (credit_ok && last_blk) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && bus.frame_last_o) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Block walk: base advances one column per block, skipping the last
  // column of each row because a 2x2 window cannot start there.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_base_q <= '0;
      blk_col_q  <= '0;
      sub_q      <= '0;
      rd_pend_q  <= 1'b0;
      side_q     <= '0;
    end else begin
      rd_pend_q <= issue;
      if (issue) side_q <= {last_blk, sub_q == POS_BR, sub_q};
      if (start_acc) begin
        blk_base_q <= '0;
        blk_col_q  <= '0;
        sub_q      <= '0;
      end else if (issue) begin
        sub_q <= sub_q + 2'd1;
        if (sub_q == POS_BR) begin
          if (blk_col_q == LAST_COL) begin
            blk_base_q <= blk_base_q + CELL_ADDR_W'(2);
            blk_col_q  <= '0;
          end else begin
            blk_base_q <= blk_base_q + CELL_ADDR_W'(1);
            blk_col_q  <= blk_col_q + COL_W'(1);
          end
        end
      end
    end
  end

  // Cache data arrives the cycle after issue and is pushed with its sideband.
  cell_fetch_fifo #(
    .WIDTH (CELL_WIDTH + 4)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_data ({side_q, bus.cell_rd_data_i}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.cell_rd_en_o   = issue;
  assign bus.cell_rd_addr_o = blk_base_q + ofs;
  assign bus.cell_valid_o   = ~fifo_empty;
  // stale FIFO contents never leak onto the bus while nothing is valid
  assign {bus.frame_last_o, bus.blk_last_o, bus.cell_pos_o, bus.cell_data_o} =
    fifo_empty ? '0 : fifo_dout;
  assign busy_o = (state_q != ST_IDLE);

`ifdef CELL_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt_o <= '0;
    end else if (bus.cell_valid_o && !bus.cell_ready_i && stall_cnt_o != 16'hFFFF) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cell_fetch_scheduler.sv
// tb/tb_cell_fetch_scheduler.sv - randomized self-checking bench for cell_fetch_scheduler
// Purpose: drives frames against a cache model and checks the beat stream
// against a block-order reference built from frame geometry.
// Ports: none. Honours CELL_FETCH_PERF_EN for stall_cnt_o.
module tb_cell_fetch_scheduler;

  localparam int W     = 768;
  localparam int AW    = 11;
  localparam int NCELL = 1200;
  localparam int COLS  = 40;
  localparam int BROWS = 29;
  localparam int BCOLS = 39;
  localparam int NBEAT = 4524;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   pos;
    logic         blk_last;
    logic         frame_last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic fetch_start_i;
  logic busy_o;
  logic done_o;
`ifdef CELL_FETCH_PERF_EN
  logic [15:0] stall_cnt_o;
`endif

  cell_fetch_scheduler_if #(.CELL_WIDTH(W), .CELL_ADDR_W(AW)) bus();

  cell_fetch_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_start_i (fetch_start_i),
    .bus           (bus),
    .busy_o        (busy_o),
    .done_o        (done_o)
`ifdef CELL_FETCH_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cache model: registered read, one cycle latency
  logic [W-1:0] cache_mem [NCELL];
  always @(posedge clk) begin
    if (bus.cell_rd_en_o) bus.cell_rd_data_i <= cache_mem[bus.cell_rd_addr_o];
  end

  // 0 = always ready, 1 = random 50%, 2 = held low
  int ready_mode = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus.cell_ready_i = 1'b1;
      1:       bus.cell_ready_i = 1'($urandom_range(0, 1));
      default: bus.cell_ready_i = 1'b0;
    endcase
  end

  beat_t exp_q[$];
  int    addr_q[$];
  int    issued, popped, beat_cnt, done_cnt, stall_seen;
  int    first_rd_cyc, first_vld_cyc, done_cyc, t_start;
  bit    mon_en = 1'b0;
  bit    saw_last_rd;
  bit    prev_stall;
  beat_t prev_beat;

  always @(negedge clk) begin
    if (mon_en) begin
      int pop_now;
      pop_now = (bus.cell_valid_o && bus.cell_ready_i) ? 1 : 0;
      if (bus.cell_rd_en_o) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (addr_q.size() == 0) check("rd_extra", 1, 0);
        else                    check("rd_addr", bus.cell_rd_addr_o, addr_q.pop_front());
        if (bus.cell_rd_addr_o == AW'(NCELL - 1)) saw_last_rd = 1'b1;
        check("credit_le3", ((issued + 1 - popped - pop_now) <= 3), 1);
        issued++;
      end
      if (prev_stall) begin
        check("hold_valid", bus.cell_valid_o, 1);
        check("hold_data", bus.cell_data_o, prev_beat.data);
        check("hold_side", {bus.cell_pos_o, bus.blk_last_o, bus.frame_last_o},
              {prev_beat.pos, prev_beat.blk_last, prev_beat.frame_last});
      end
      if (bus.cell_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.cell_valid_o && !bus.cell_ready_i) stall_seen++;
      if (pop_now == 1) begin
        if (exp_q.size() == 0) begin
          check("beat_extra", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", bus.cell_data_o, e.data);
          check("beat_pos", bus.cell_pos_o, e.pos);
          check("beat_blk_last", bus.blk_last_o, e.blk_last);
          check("beat_frame_last", bus.frame_last_o, e.frame_last);
        end
        popped++;
        beat_cnt++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_on_last", (pop_now == 1) && bus.frame_last_o, 1);
      end
      prev_stall          = bus.cell_valid_o && !bus.cell_ready_i;
      prev_beat.data       = bus.cell_data_o;
      prev_beat.pos        = bus.cell_pos_o;
      prev_beat.blk_last   = bus.blk_last_o;
      prev_beat.frame_last = bus.frame_last_o;
    end
  end

  // Reference: walk blocks row-major, each block TL,TR,BL,BR.
  task automatic prep_frame();
    for (int i = 0; i < NCELL; i++)
      for (int k = 0; k < W / 32; k++)
        cache_mem[i][k*32 +: 32] = $urandom();
    exp_q.delete();
    addr_q.delete();
    for (int r = 0; r < BROWS; r++) begin
      for (int c = 0; c < BCOLS; c++) begin
        for (int s = 0; s < 4; s++) begin
          beat_t b;
          int    a;
          a = (r + s / 2) * COLS + c + (s % 2);
          b.data       = cache_mem[a];
          b.pos        = 2'(s);
          b.blk_last   = (s == 3);
          b.frame_last = (r == BROWS - 1) && (c == BCOLS - 1) && (s == 3);
          exp_q.push_back(b);
          addr_q.push_back(a);
        end
      end
    end
    issued = 0; popped = 0; beat_cnt = 0; done_cnt = 0; stall_seen = 0;
    first_rd_cyc = -1; first_vld_cyc = -1; done_cyc = -1;
    saw_last_rd = 1'b0; prev_stall = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    fetch_start_i = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    fetch_start_i = 1'b0;
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_rd_en"}, bus.cell_rd_en_o, 0);
    check({pfx, "_rd_addr"}, bus.cell_rd_addr_o, 0);
    check({pfx, "_valid"}, bus.cell_valid_o, 0);
    check({pfx, "_data"}, bus.cell_data_o, 0);
    check({pfx, "_pos"}, bus.cell_pos_o, 0);
    check({pfx, "_blk_last"}, bus.blk_last_o, 0);
    check({pfx, "_frame_last"}, bus.frame_last_o, 0);
    check({pfx, "_busy"}, busy_o, 0);
    check({pfx, "_done"}, done_o, 0);
`ifdef CELL_FETCH_PERF_EN
    check({pfx, "_stall_cnt"}, stall_cnt_o, 0);
`endif
  endtask

  task automatic run_frame(input int mode, input bit extra_starts, input bit stall_test);
    int n;
    int i0;
    bit p1, p2;
    prep_frame();
    ready_mode = stall_test ? 2 : mode;
    pulse_start();
    if (stall_test) begin
      repeat (19) @(posedge clk);
      #1;
      check("stall_reads", issued, 3);
      n = 0;
      while (stall_seen < 37 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      ready_mode = mode;
      i0 = issued;
      repeat (10) @(negedge clk);
      #1;
      check("resume_reads", issued - i0, 10);
    end
    n = 0; p1 = 1'b0; p2 = 1'b0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      fetch_start_i = 1'b0;
      if (extra_starts && !p1 && beat_cnt >= 100) begin
        fetch_start_i = 1'b1;
        p1 = 1'b1;
      end else if (extra_starts && !p2 && saw_last_rd && done_cnt == 0) begin
        fetch_start_i = 1'b1;
        p2 = 1'b1;
      end
    end
    fetch_start_i = 1'b0;
    check("frame_timeout", done_cnt > 0, 1);
    repeat (10) @(posedge clk);
    #1;
    check("lat_first_rd", first_rd_cyc - t_start, 1);
    check("lat_first_valid", first_vld_cyc - t_start, 3);
    check("beat_count", beat_cnt, NBEAT);
    check("done_count", done_cnt, 1);
    check("exp_left", exp_q.size(), 0);
    check("addr_left", addr_q.size(), 0);
    check("busy_after", busy_o, 0);
    if (mode == 0 && !stall_test) check("done_cycle", done_cyc - t_start, 4526);
`ifdef CELL_FETCH_PERF_EN
    check("stall_cnt", stall_cnt_o, stall_seen);
    if (stall_test) check("stall_cnt_37", stall_cnt_o, 37);
`endif
  endtask

  task automatic reset_mid_frame();
    int n;
    prep_frame();
    ready_mode = 0;
    pulse_start();
    n = 0;
    while (beat_cnt < 2000 && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reached_2000", beat_cnt >= 2000, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
  endtask

  initial begin
    rst = 1'b1;
    fetch_start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    run_frame(0, 1'b0, 1'b0);   // full throughput, exact timing
    run_frame(1, 1'b0, 1'b0);   // random backpressure
    run_frame(0, 1'b0, 1'b1);   // ready held low after start
    run_frame(1, 1'b1, 1'b0);   // stray starts mid-frame and in drain
    reset_mid_frame();
    run_frame(1, 1'b0, 1'b0);   // clean restart after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
